// File: rtl/corner_kernel_stream.sv
// corner_kernel_stream
// Streaming 3x3 border thinning with optional Moravec corner detection.
// Pixels arrive in raster order with a start-of-frame flag. Two line
// buffers plus a 3x3 shift window feed a one-stage classifier. Results
// are produced only for interior centers.
// The corner scoring path is built only when the macro
// CORNER_KERNEL_MORAVEC_EN is defined. Without it, every border pixel is
// output as 0, out_corner is 0 and corner_count stays 0. Latency and
// handshake are the same in both builds.
module corner_kernel_stream #(
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int PIXEL_W   = 8,
    parameter int BORDER_TH = 1,
    parameter int CORNER_TH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sof,
    input  logic [PIXEL_W-1:0] in_pixel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIXEL_W-1:0] out_pixel,
    output logic               out_corner,
    output logic               out_eof,
    output logic [15:0]        corner_count
);

    localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int SW  = 2 * PIXEL_W + 2;
    localparam int PW1 = PIXEL_W + 1;

    localparam logic [CW-1:0]  COL_ZERO    = CW'(0);
    localparam logic [CW-1:0]  COL_ONE     = CW'(1);
    localparam logic [CW-1:0]  COL_TWO     = CW'(2);
    localparam logic [CW-1:0]  COL_LAST    = CW'(IMG_W - 1);
    localparam logic [RW-1:0]  ROW_ZERO    = RW'(0);
    localparam logic [RW-1:0]  ROW_ONE     = RW'(1);
    localparam logic [RW-1:0]  ROW_TWO     = RW'(2);
    localparam logic [RW-1:0]  ROW_LAST    = RW'(IMG_H - 1);
    localparam logic [PW1-1:0] BORDER_TH_S = PW1'(BORDER_TH);

    // Elaboration-time sanity checks on the configuration.
    if (IMG_W < 3) begin : g_bad_img_w
        $error("corner_kernel_stream: IMG_W must be at least 3");
    end
    if (IMG_H < 3) begin : g_bad_img_h
        $error("corner_kernel_stream: IMG_H must be at least 3");
    end
    if (PIXEL_W < 1) begin : g_bad_pixel_w
        $error("corner_kernel_stream: PIXEL_W must be at least 1");
    end
    if (CORNER_TH < 0) begin : g_bad_corner_th
        $error("corner_kernel_stream: CORNER_TH must not be negative");
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [PIXEL_W-1:0] pix_max(input logic [PIXEL_W-1:0] a,
                                                   input logic [PIXEL_W-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    function automatic logic [PIXEL_W-1:0] pix_min(input logic [PIXEL_W-1:0] a,
                                                   input logic [PIXEL_W-1:0] b);
        return (a <= b) ? a : b;
    endfunction

    // ------------------------------------------------------------------
    // Handshake and position tracking
    // ------------------------------------------------------------------
    logic               adv_s;       // whole pipeline advances this cycle
    logic               acc_s;       // input handshake completes
    logic               sof_take_s;  // accepted start-of-frame pixel
    logic               take_s;      // accepted pixel that belongs to a frame
    logic [CW-1:0]      col_r;
    logic [RW-1:0]      row_r;
    logic               synced_r;    // an in_sof has been seen since reset
    logic [CW-1:0]      cur_col_s;
    logic [RW-1:0]      cur_row_s;

    assign adv_s      = !out_valid || out_ready;
    assign in_ready   = adv_s;
    assign acc_s      = in_valid && adv_s;
    assign sof_take_s = acc_s && in_sof;
    assign take_s     = acc_s && (in_sof || synced_r);

    // Position of the pixel on the input: in_sof forces it to (0,0).
    always_comb begin
        cur_col_s = col_r;
        cur_row_s = row_r;
        if (in_sof) begin
            cur_col_s = COL_ZERO;
            cur_row_s = ROW_ZERO;
        end else begin
            cur_col_s = col_r;
            cur_row_s = row_r;
        end
    end

    // Raster counters: advance on every taken pixel, wrap at frame edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r    <= COL_ZERO;
            row_r    <= ROW_ZERO;
            synced_r <= 1'b0;
        end else if (take_s) begin
            synced_r <= 1'b1;
            if (cur_col_s == COL_LAST) begin
                col_r <= COL_ZERO;
                row_r <= (cur_row_s == ROW_LAST) ? ROW_ZERO : (cur_row_s + ROW_ONE);
            end else begin
                col_r <= cur_col_s + COL_ONE;
                row_r <= cur_row_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers and 3x3 window (no reset: the row counters gate use)
    // ------------------------------------------------------------------
    logic [PIXEL_W-1:0] lb_top_r [IMG_W];  // row r-2
    logic [PIXEL_W-1:0] lb_mid_r [IMG_W];  // row r-1
    logic [PIXEL_W-1:0] win_r    [3][3];   // [row][col], [0][0] = NW

    // Shift the window left and feed the new column from the line buffers.
    always_ff @(posedge clk) begin
        if (take_s) begin
            lb_top_r[cur_col_s] <= lb_mid_r[cur_col_s];
            lb_mid_r[cur_col_s] <= in_pixel;
            for (int i = 0; i < 3; i++) begin
                win_r[i][0] <= win_r[i][1];
                win_r[i][1] <= win_r[i][2];
            end
            win_r[0][2] <= lb_top_r[cur_col_s];
            win_r[1][2] <= lb_mid_r[cur_col_s];
            win_r[2][2] <= in_pixel;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: window valid flags
    // ------------------------------------------------------------------
    logic s1_valid_r;
    logic s1_eof_r;

    // A window is complete once its SE pixel (row>=2, col>=2) is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_eof_r   <= 1'b0;
        end else if (adv_s) begin
            s1_valid_r <= take_s && (cur_row_s >= ROW_TWO) && (cur_col_s >= COL_TWO);
            s1_eof_r   <= (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Classification of the window held in stage 1
    // ------------------------------------------------------------------
    logic [PIXEL_W-1:0] c_s, n_s, s_s, w_s, e_s;
    logic [PIXEL_W-1:0] max_s, min_s;
    logic [PW1-1:0]     range_s;
    logic               border_s;
    logic               corner_s;

    assign c_s = win_r[1][1];
    assign n_s = win_r[0][1];
    assign s_s = win_r[2][1];
    assign w_s = win_r[1][0];
    assign e_s = win_r[1][2];

    // Border test: spread of the plus-shaped neighbourhood, non-zero center.
    always_comb begin
        max_s    = pix_max(pix_max(pix_max(c_s, n_s), pix_max(s_s, w_s)), e_s);
        min_s    = pix_min(pix_min(pix_min(c_s, n_s), pix_min(s_s, w_s)), e_s);
        range_s  = {1'b0, max_s} - {1'b0, min_s};
        border_s = (range_s >= BORDER_TH_S) && (c_s != {PIXEL_W{1'b0}});
    end

`ifdef CORNER_KERNEL_MORAVEC_EN
    localparam logic [SW-1:0] CORNER_TH_S = SW'(CORNER_TH);

    logic [PIXEL_W-1:0] nw_s, ne_s, sw_s, se_s;
    logic [SW-1:0]      d1_s, d2_s, d3_s, d4_s, dmin_s;

    assign nw_s = win_r[0][0];
    assign ne_s = win_r[0][2];
    assign sw_s = win_r[2][0];
    assign se_s = win_r[2][2];

    function automatic logic [SW-1:0] sq_diff(input logic [PIXEL_W-1:0] a,
                                              input logic [PIXEL_W-1:0] b);
        logic [PIXEL_W-1:0]   d;
        logic [2*PIXEL_W-1:0] p;
        d = (a >= b) ? (a - b) : (b - a);
        p = {{PIXEL_W{1'b0}}, d} * {{PIXEL_W{1'b0}}, d};
        return {2'b00, p};
    endfunction

    function automatic logic [SW-1:0] score4(input logic [PIXEL_W-1:0] c,
                                             input logic [PIXEL_W-1:0] a,
                                             input logic [PIXEL_W-1:0] b,
                                             input logic [PIXEL_W-1:0] d,
                                             input logic [PIXEL_W-1:0] e);
        return sq_diff(c, a) + sq_diff(c, b) + sq_diff(c, d) + sq_diff(c, e);
    endfunction

    // Moravec score: weakest of the four directional SSDs.
    always_comb begin
        d1_s     = score4(c_s, w_s, nw_s, n_s, ne_s);
        d2_s     = score4(c_s, n_s, ne_s, e_s, se_s);
        d3_s     = score4(c_s, e_s, se_s, s_s, sw_s);
        d4_s     = score4(c_s, s_s, sw_s, w_s, nw_s);
        dmin_s   = (d1_s <= d2_s) ? d1_s : d2_s;
        dmin_s   = (dmin_s <= d3_s) ? dmin_s : d3_s;
        dmin_s   = (dmin_s <= d4_s) ? dmin_s : d4_s;
        corner_s = border_s && (dmin_s >= CORNER_TH_S);
    end
`else
    assign corner_s = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage 2: registered outputs
    // ------------------------------------------------------------------
    // Load the result on advance; an accepted in_sof drops the stage-1 entry
    // so nothing from the old frame follows the result already on the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_pixel  <= {PIXEL_W{1'b0}};
            out_corner <= 1'b0;
            out_eof    <= 1'b0;
        end else if (adv_s) begin
            out_valid <= s1_valid_r && !sof_take_s;
            if (s1_valid_r) begin
                out_pixel  <= (!border_s || corner_s) ? c_s : {PIXEL_W{1'b0}};
                out_corner <= corner_s;
                out_eof    <= s1_eof_r;
            end else begin
                out_pixel  <= {PIXEL_W{1'b0}};
                out_corner <= 1'b0;
                out_eof    <= 1'b0;
            end
        end
    end

    // Per-frame corner counter: cleared by in_sof, saturating at 0xFFFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corner_count <= 16'h0000;
        end else if (sof_take_s) begin
            corner_count <= (out_valid && out_ready && out_corner) ? 16'h0001 : 16'h0000;
        end else if (out_valid && out_ready && out_corner && (corner_count != 16'hFFFF)) begin
            corner_count <= corner_count + 16'h0001;
        end
    end

endmodule

// File: tb/tb_corner_kernel_stream.sv
// Directed bench for corner_kernel_stream: flat, isolated pixel, vertical
// edge, backpressure, mid-frame resync and mid-frame reset. Expected results
// come from a frame-level model of the classification rules.
module tb_corner_kernel_stream;

    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int PW    = 8;
    localparam int BTH   = 1;
    localparam int CTH   = 1;

`ifdef CORNER_KERNEL_MORAVEC_EN
    localparam int ISO_PIX = 200;
    localparam int ISO_COR = 1;
    localparam int RS_PIX  = 24;
`else
    localparam int ISO_PIX = 0;
    localparam int ISO_COR = 0;
    localparam int RS_PIX  = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [PW-1:0] in_pixel = '0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic          out_valid;
    logic [PW-1:0] out_pixel;
    logic          out_corner;
    logic          out_eof;
    logic [15:0]   corner_count;

    corner_kernel_stream #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIXEL_W(PW),
        .BORDER_TH(BTH), .CORNER_TH(CTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_corner(out_corner), .out_eof(out_eof), .corner_count(corner_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int img [IMG_H][IMG_W];
    int q_pix [$];
    bit q_cor [$];
    bit q_eof [$];
    int exp_cnt = 0;
    int rcv_cnt = 0;
    int stall_at = -1;
    int stall_left = 0;
    int stall_seen = 0;
    bit hold_prev = 1'b0;
    logic [PW-1:0] hold_pix;
    logic hold_cor, hold_eof;
    int first_v_cyc = -1;
    int last_acc_cyc = -1;
    int acc18_cyc = -1;
    int mon_p;
    bit mon_c, mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sqd(input int a, input int b);
        return (a - b) * (a - b);
    endfunction

    // Frame-level model of one interior center.
    task automatic model(input int r, input int c, output int pix, output bit cor);
        int cc, mx, mn, dmin;
        int nb[5];
        int d[4];
        bit border;
        cc = img[r][c];
        nb = '{cc, img[r-1][c], img[r+1][c], img[r][c-1], img[r][c+1]};
        mx = cc; mn = cc;
        foreach (nb[i]) begin
            if (nb[i] > mx) mx = nb[i];
            if (nb[i] < mn) mn = nb[i];
        end
        border = (mx - mn >= BTH) && (cc != 0);
        d[0] = sqd(cc, img[r][c-1]) + sqd(cc, img[r-1][c-1]) + sqd(cc, img[r-1][c]) + sqd(cc, img[r-1][c+1]);
        d[1] = sqd(cc, img[r-1][c]) + sqd(cc, img[r-1][c+1]) + sqd(cc, img[r][c+1]) + sqd(cc, img[r+1][c+1]);
        d[2] = sqd(cc, img[r][c+1]) + sqd(cc, img[r+1][c+1]) + sqd(cc, img[r+1][c]) + sqd(cc, img[r+1][c-1]);
        d[3] = sqd(cc, img[r+1][c]) + sqd(cc, img[r+1][c-1]) + sqd(cc, img[r][c-1]) + sqd(cc, img[r-1][c-1]);
        dmin = d[0];
        foreach (d[i]) if (d[i] < dmin) dmin = d[i];
`ifdef CORNER_KERNEL_MORAVEC_EN
        cor = border && (dmin >= CTH);
`else
        cor = 1'b0;
`endif
        pix = (!border || cor) ? cc : 0;
    endtask

    task automatic push_one(input int r, input int c);
        int p;
        bit co;
        model(r, c, p, co);
        q_pix.push_back(p);
        q_cor.push_back(co);
        q_eof.push_back((r == IMG_H - 2) && (c == IMG_W - 2));
    endtask

    task automatic push_all();
        for (int r = 1; r < IMG_H - 1; r++)
            for (int c = 1; c < IMG_W - 1; c++)
                push_one(r, c);
    endtask

    task automatic fill(input int kind);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                case (kind)
                    0: img[r][c] = 50;
                    1: img[r][c] = (r == 3 && c == 3) ? 200 : 0;
                    2: img[r][c] = (c >= 4) ? 100 : 0;
                    3: img[r][c] = r * 16 + c * 8;
                    default: img[r][c] = (r * 29 + c * 53 + r * c * 7) % 256;
                endcase
    endtask

    // Present one pixel and wait (bounded) for it to be accepted.
    task automatic send(input int p, input bit sof);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_pixel = p[PW-1:0];
        in_sof = sof;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) last_acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready stuck low, expected accept of pixel %0d", p);
        end
    endtask

    task automatic stream(input int first, input int last, input bit sof_first);
        for (int idx = first; idx <= last; idx++) begin
            send(img[idx / IMG_W][idx % IMG_W], sof_first && (idx == first));
            if (idx == 18) acc18_cyc = last_acc_cyc;
        end
        in_sof = 1'b0;
    endtask

    task automatic drain(input string name);
        in_valid = 1'b0;
        in_sof = 1'b0;
        for (int k = 0; k < 60 && q_pix.size() != 0; k++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        check(name, q_pix.size(), 0);
    endtask

    // Result consumer side: stall out_ready for a programmed window.
    always @(posedge clk) begin
        #2;
        if (stall_left > 0 && out_valid && rcv_cnt == stall_at) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Compare process: handshake, hold, counter and scoreboard every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", in_ready, (!out_valid || out_ready));
            check("corner_count", corner_count, exp_cnt);
            if (out_valid && !out_ready) begin
                stall_seen++;
                check("stall_in_ready", in_ready, 0);
                if (hold_prev) begin
                    check("hold_pixel", out_pixel, hold_pix);
                    check("hold_corner", out_corner, hold_cor);
                    check("hold_eof", out_eof, hold_eof);
                end
                hold_prev = 1'b1;
                hold_pix = out_pixel;
                hold_cor = out_corner;
                hold_eof = out_eof;
            end else begin
                hold_prev = 1'b0;
            end
            if (out_valid && first_v_cyc < 0) first_v_cyc = cyc;
            if (in_valid && in_ready && in_sof) exp_cnt = 0;
            if (out_valid && out_ready) begin
                if (q_pix.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got pixel %0d, expected no result", out_pixel);
                end else begin
                    mon_p = q_pix.pop_front();
                    mon_c = q_cor.pop_front();
                    mon_e = q_eof.pop_front();
                    check("out_pixel", out_pixel, mon_p);
                    check("out_corner", out_corner, mon_c);
                    check("out_eof", out_eof, mon_e);
                    if (mon_c) exp_cnt++;
                end
                rcv_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mp;
        bit mc;

        // Reset state, checked before any clock edge.
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pixel", out_pixel, 0);
        check("rst_out_corner", out_corner, 0);
        check("rst_out_eof", out_eof, 0);
        check("rst_corner_count", corner_count, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Flat frame.
        fill(0);
        model(3, 3, mp, mc);
        check("pin_flat_pix", mp, 50);
        check("pin_flat_cor", mc, 0);
        push_all();
        rcv_cnt = 0;
        first_v_cyc = -1;
        stream(0, IMG_W * IMG_H - 1, 1'b1);
        drain("flat_drain");
        check("flat_latency", first_v_cyc - acc18_cyc, 2);
        check("flat_results", rcv_cnt, 36);
        check("flat_count", corner_count, 0);

        // Isolated bright pixel.
        fill(1);
        model(3, 3, mp, mc);
        check("pin_iso_pix", mp, ISO_PIX);
        check("pin_iso_cor", mc, ISO_COR);
        model(2, 3, mp, mc);
        check("pin_iso_nb", mp, 0);
        push_all();
        rcv_cnt = 0;
        stream(0, IMG_W * IMG_H - 1, 1'b1);
        drain("iso_drain");
        check("iso_results", rcv_cnt, 36);
        check("iso_count", corner_count, ISO_COR);

        // Vertical edge.
        fill(2);
        model(3, 4, mp, mc);
        check("pin_edge_c4", mp, 0);
        model(3, 5, mp, mc);
        check("pin_edge_c5", mp, 100);
        model(3, 3, mp, mc);
        check("pin_edge_c3", mp, 0);
        push_all();
        rcv_cnt = 0;
        stream(0, IMG_W * IMG_H - 1, 1'b1);
        drain("edge_drain");
        check("edge_count", corner_count, 0);

        // Backpressure at result 10.
        fill(4);
        push_all();
        rcv_cnt = 0;
        stall_seen = 0;
        stall_at = 9;
        stall_left = 5;
        stream(0, IMG_W * IMG_H - 1, 1'b1);
        drain("bp_drain");
        check("bp_stall_cycles", stall_seen, 5);
        check("bp_results", rcv_cnt, 36);

        // Mid-frame resync on pixel 20: only result (1,1) of the old frame.
        fill(3);
        model(1, 1, mp, mc);
        check("pin_rs_pix", mp, RS_PIX);
        push_one(1, 1);
        rcv_cnt = 0;
        stream(0, 19, 1'b1);
        fill(0);
        push_all();
        stream(0, IMG_W * IMG_H - 1, 1'b1);
        drain("rs_drain");
        check("rs_results", rcv_cnt, 37);
        check("rs_count", corner_count, ISO_COR);

        // Reset while pixel 30 is on the input.
        fill(4);
        for (int r = 1; r <= 2; r++)
            for (int c = 1; c < ((r == 1) ? IMG_W - 1 : 5); c++)
                push_one(r, c);
        rcv_cnt = 0;
        stream(0, 29, 1'b1);
        in_pixel = img[3][6][PW-1:0];
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_eof", out_eof, 0);
        check("arst_count", corner_count, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_results_before", rcv_cnt, 8);
        q_pix.delete();
        q_cor.delete();
        q_eof.delete();
        exp_cnt = 0;
        hold_prev = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) send(77, 1'b0);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("arst_no_output", rcv_cnt, 8);
        fill(2);
        push_all();
        rcv_cnt = 0;
        stream(0, IMG_W * IMG_H - 1, 1'b1);
        drain("arst_drain");
        check("arst_new_results", rcv_cnt, 36);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/corner_kernel_stream.md
CORNER_KERNEL_STREAM -- requirements
Module: corner_kernel_stream

Interface
REQ-001 SHALL have parameter IMG_W, default 8: image width in pixels, at least 3.
REQ-002 SHALL have parameter IMG_H, default 8: image height in pixels, at least 3.
REQ-003 SHALL have parameter PIXEL_W, default 8: pixel bit width.
REQ-004 SHALL have parameter BORDER_TH, default 1: minimum neighbourhood range for a pixel to count as border.
REQ-005 SHALL have parameter CORNER_TH, default 1: minimum Moravec score for a pixel to count as corner.
REQ-006 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input accept.
- in_sof  in  1  marks the first pixel of a frame, raster order.
- in_pixel  in  PIXEL_W  input pixel.
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- out_pixel  out  PIXEL_W  thinned result pixel.
- out_corner  out  1  result classified as corner.
- out_eof  out  1  last result of the frame.
- corner_count  out  16  corners seen in the current frame; saturates at 0xFFFF.

Function
REQ-007 SHALL store IMG_W-deep line buffers for the two previous rows and form a 3x3 window: NW N NE / W C E / SW S SE.
REQ-008 SHALL produce results only for interior centers, rows 1..IMG_H-2 and cols 1..IMG_W-2, in raster order: (IMG_H-2)*(IMG_W-2) results per frame.
REQ-009 SHALL treat a pixel as accepted when in_valid and in_ready are both high; col/row counters advance only on accept and wrap at IMG_W and IMG_H.
REQ-010 SHALL set in_ready = !out_valid || out_ready, and the whole pipeline SHALL stall on the same condition.
REQ-011 SHALL assert out_valid exactly 2 advancing cycles after the accept of the pixel that completes the window, the SE pixel at (r+1,c+1).
REQ-012 SHALL compute range = max - min over {C, N, W, E, S}; the pixel is border when range >= BORDER_TH and C != 0.
REQ-013 SHALL compute Moravec direction scores as sums of (C-x)^2 over the following sets, each score 2*PIXEL_W+2 bits wide with no overflow.
- D1: {W, NW, N, NE}
- D2: {N, NE, E, SE}
- D3: {E, SE, S, SW}
- D4: {S, SW, W, NW}
REQ-014 SHALL set corner = border and min(D1..D4) >= CORNER_TH.
REQ-015 SHALL output out_pixel = C when the pixel is not border or is corner, and 0 otherwise.
REQ-016 SHALL hold out_pixel, out_corner and out_eof stable while out_valid is high and out_ready is low.
REQ-017 SHALL assert out_eof with the result for center (IMG_H-2, IMG_W-2).
REQ-018 SHALL increment corner_count on each accepted result with out_corner=1.
REQ-019 SHALL clear corner_count on an accepted in_sof pixel; when a corner result is accepted in the same cycle, corner_count SHALL become 1.
REQ-020 SHALL handle accepted in_sof mid-frame as follows.
- The counters resync so this pixel is (0,0).
- Pipeline stages not yet presented SHALL be invalidated.
- A result already presented on the output SHALL remain until accepted.
REQ-021 SHALL ignore in_pixel while in_valid is low, and SHALL NOT accept pixels before the first in_sof after reset.

Reset
REQ-022 SHALL, on rst_n low, immediately clear out_valid, out_pixel, out_corner, out_eof, corner_count, counters and pipeline valids to 0, and set in_ready to 1.
REQ-023 SHALL leave line buffer contents undefined after reset; the row counters gate their use.
REQ-024 SHALL require an in_sof pixel to restart processing after reset mid-frame.

Configuration
REQ-025 SHALL implement the corner path under the macro CORNER_KERNEL_MORAVEC_EN.
- Defined: score logic per REQ-013/014 is built.
- Undefined: no score logic; corner=0, out_corner=0, corner_count stays 0, all border pixels output 0.
- Latency and handshake SHALL be identical in both builds.

Verification
REQ-026 SHALL check a flat frame, with all parameters at defaults: all pixels 50 -> 36 results of 50, out_corner 0, out_eof on result 36, corner_count 0.
REQ-027 SHALL check an isolated bright pixel: 0 background with 200 at (3,3) -> result (3,3) = 200 with out_corner=1, all other results 0, corner_count 1.
REQ-028 SHALL check a vertical edge: cols 0-3 = 0, cols 4-7 = 100 -> col-4 results 0 (border, D2 = 0), col-5/6 results 100, no corners.
REQ-029 SHALL check backpressure: out_ready low for 5 cycles at result 10 -> in_ready low, out_* held, and the full result sequence matches the no-stall run.
REQ-030 SHALL check mid-frame resync: in_sof reasserted on pixel 20 -> no stale results after the presented one, then 36 results from the new frame.
REQ-031 SHALL check reset mid-frame: rst_n low at pixel 30 -> out_valid 0 without a clock edge, and no output until a new in_sof frame completes its window.
